// File: rtl/fifo_pkg.sv
// Shared definitions for the 3-bit async FIFO and its read-side consumers.
// Holds the symbol width default, packer state encoding and a clog2 helper.
package fifo_pkg;

    localparam int unsigned FIFO_DW = 3;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } pack_state_t;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < v)
            r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/pack_idle_timer.sv
// Idle down-counter for the packer: reloads on clr, counts down on en,
// and flags expire on the enabled cycle that finds it at zero.
module pack_idle_timer
    import fifo_pkg::*;
#(
    parameter int unsigned TO_CYC = 16,
    localparam int unsigned TW = (TO_CYC > 1) ? clog2(TO_CYC) : 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= TW'(TO_CYC - 1);
        end else if (clr) begin
            cnt <= TW'(TO_CYC - 1);
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/fifo_drain_packer.sv
// Read-domain consumer of the async FIFO: packs PACK symbols per output word.
// Optional partial-word timeout flush is enabled by defining PACK_FLUSH_EN.
module fifo_drain_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DW     = FIFO_DW,
    parameter int unsigned PACK   = 4,
    parameter int unsigned TO_CYC = 16,
    localparam int unsigned OW    = DW * PACK,
    localparam int unsigned CW    = clog2(PACK + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fifo_empty,
    output logic          fifo_ren,
    input  logic [DW-1:0] fifo_dout,
    output logic [OW-1:0] out_data,
    output logic [CW-1:0] out_cnt,
    output logic          out_valid,
    input  logic          out_ready
);

    pack_state_t   state, state_nxt;
    logic [CW-1:0] count;
    logic          inflight;
    logic [DW-1:0] slot [PACK];
    logic [CW:0]   inuse;
    logic [CW-1:0] filled;
    logic [OW-1:0] word_nxt;
    logic          load;
    logic          idle_exp;

    // inuse counts popped-but-not-captured symbols so the last slot is never over-popped
    assign inuse  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign filled = count + CW'(inflight);

`ifdef PACK_FLUSH_EN
    logic idle_en;

    assign idle_en = (state == COLLECT) && (count != '0) && (count < CW'(PACK))
                     && !inflight && !fifo_ren;

    pack_idle_timer #(
        .TO_CYC (TO_CYC)
    ) u_idle_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (inflight),
        .en     (idle_en),
        .expire (idle_exp)
    );
`else
    // no partial flush in this build; TO_CYC kept for a uniform parameter list
    assign idle_exp = 1'b0 && (TO_CYC != 0);
`endif

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        fifo_ren  = 1'b0;
        case (state)
            COLLECT: begin
                fifo_ren = !fifo_empty && (inuse < (CW + 1)'(PACK));
                if ((inflight && (filled == CW'(PACK))) || idle_exp) begin
                    state_nxt = HOLD;
                    load      = 1'b1;
                end
            end
            HOLD: begin
                if (out_ready)
                    state_nxt = COLLECT;
            end
            default: state_nxt = COLLECT;
        endcase
    end

    // word assembled from the slots plus the symbol being captured this cycle
    always_comb begin
        word_nxt = '0;
        for (int unsigned k = 0; k < PACK; k++) begin
            if (CW'(k) < filled)
                word_nxt[k*DW +: DW] = (inflight && (count == CW'(k))) ? fifo_dout : slot[k];
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned k = 0; k < PACK; k++) begin
            if (inflight && (count == CW'(k)))
                slot[k] <= fifo_dout;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COLLECT;
            count     <= '0;
            inflight  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_cnt   <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_ren;
            if ((state == HOLD) && out_ready) begin
                count     <= '0;
                out_valid <= 1'b0;
            end else if (inflight) begin
                count <= count + CW'(1);
            end
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= word_nxt;
                out_cnt   <= filled;
            end
        end
    end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer with a behavioural FIFO source and a
// word scoreboard; build with PACK_FLUSH_EN to exercise the partial flush.
module tb_fifo_drain_packer;

    localparam int unsigned DW   = 3;
    localparam int unsigned PACK = 4;
    localparam int unsigned OW   = DW * PACK;
    localparam int unsigned CW   = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty = 1'b1;
    logic          fifo_ren;
    logic [DW-1:0] fifo_dout = '0;
    logic [OW-1:0] out_data;
    logic [CW-1:0] out_cnt;
    logic          out_valid;
    logic          out_ready = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0]    src [$];
    logic [CW+OW-1:0] sb [$];
    logic [OW-1:0]    cur_word = '0;
    int               cur_n = 0;
    bit               gap_mode = 1'b0;
    bit               gap = 1'b0;
    bit               ren_seen = 1'b0;
    int               pop_cnt = 0;

    always #5 clk = ~clk;

    fifo_drain_packer #(
        .DW     (DW),
        .PACK   (PACK),
        .TO_CYC (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_ren   (fifo_ren),
        .fifo_dout  (fifo_dout),
        .out_data   (out_data),
        .out_cnt    (out_cnt),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // behavioural FIFO: read data appears the cycle after a sampled fifo_ren
    always @(negedge clk) ren_seen = rst_n && fifo_ren;

    always @(posedge clk) begin
        if (ren_seen) begin
            if (src.size() > 0)
                fifo_dout <= src.pop_front();
            pop_cnt++;
        end
        #2;
        if (gap_mode)
            gap = !gap;
        fifo_empty = (src.size() == 0) || (gap_mode && gap);
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("ren_while_empty", {31'd0, fifo_ren && fifo_empty}, 32'd0);
            if (out_valid) begin
                check("ren_in_hold", {31'd0, fifo_ren}, 32'd0);
                n_vec++;
                assert (sb.size() != 0) else begin
                    n_err++;
                    $error("FAIL unexpected_word: observed data %0h cnt %0d, expected no word", out_data, out_cnt);
                end
                if (sb.size() != 0) begin
                    check("word_data", 32'(out_data), 32'(sb[0][OW-1:0]));
                    check("word_cnt", 32'(out_cnt), 32'(sb[0][OW +: CW]));
                    if (out_ready)
                        void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_sym(input logic [DW-1:0] v);
        src.push_back(v);
        cur_word[cur_n*DW +: DW] = v;
        cur_n++;
        if (cur_n == PACK) begin
            sb.push_back({CW'(PACK), cur_word});
            cur_word = '0;
            cur_n = 0;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int t;
        t = 0;
        while (sb.size() != 0 && t < budget) begin
            tick();
            t++;
        end
        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL %s: observed %0d words outstanding after %0d cycles, expected 0", tag, sb.size(), budget);
        end
        tick(2);
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int t;
        t = 0;
        while (!out_valid && t < budget) begin
            tick();
            t++;
        end
        check(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int p0;
        logic [DW-1:0] r;

        // reset state
        #2;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_cnt", 32'(out_cnt), 32'd0);
        check("rst_ren", {31'd0, fifo_ren}, 32'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);
        check("idle_ren_empty", {31'd0, fifo_ren}, 32'd0);

        // burst of four with downstream ready
        out_ready = 1'b1;
        p0 = pop_cnt;
        push_sym(3'd3); push_sym(3'd5); push_sym(3'd1); push_sym(3'd7);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k <= 4)
                check("burst_pops", 32'(pop_cnt - p0), 32'(k));
            if (k == 4)
                check("burst_valid_early", {31'd0, out_valid}, 32'd0);
            if (k == 5) begin
                check("burst_valid", {31'd0, out_valid}, 32'd1);
                check("burst_data", 32'(out_data), 32'h0E6B);
            end
            if (k == 6)
                check("burst_valid_pulse", {31'd0, out_valid}, 32'd0);
        end
        tick(2);

        // backpressure: two words queued, downstream stalled
        out_ready = 1'b0;
        p0 = pop_cnt;
        push_sym(3'd4); push_sym(3'd2); push_sym(3'd6); push_sym(3'd0);
        push_sym(3'd1); push_sym(3'd3); push_sym(3'd5); push_sym(3'd7);
        tick(20);
        check("bp_pops_stalled", 32'(pop_cnt - p0), 32'd4);
        check("bp_src_left", 32'(src.size()), 32'd4);
        check("bp_valid_held", {31'd0, out_valid}, 32'd1);
        out_ready = 1'b1;
        drain("bp_drain", 40);
        check("bp_pops_total", 32'(pop_cnt - p0), 32'd8);

        // empty flag toggling every cycle
        gap_mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            r = DW'($urandom_range(0, 7));
            push_sym(r);
        end
        drain("gap_drain", 80);
        gap_mode = 1'b0;
        tick(2);

        // partial word then silence
        push_sym(3'd2); push_sym(3'd6);
`ifdef PACK_FLUSH_EN
        sb.push_back({CW'(cur_n), cur_word});
        cur_word = '0;
        cur_n = 0;
        drain("flush_drain", 60);
        check("flush_sb_data_const", 32'(out_data), 32'h032);
        push_sym(3'd1); push_sym(3'd4);
        tick(6);
`else
        tick(40);
        check("no_flush_valid", {31'd0, out_valid}, 32'd0);
`endif

        // reset with two symbols captured
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        cur_word = '0;
        cur_n = 0;
        #1;
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_ren", {31'd0, fifo_ren}, 32'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        push_sym(3'd7); push_sym(3'd0); push_sym(3'd2); push_sym(3'd5);
        drain("clean_word_drain", 30);

        // asynchronous reset while a word is held
        out_ready = 1'b0;
        push_sym(3'd6); push_sym(3'd6); push_sym(3'd1); push_sym(3'd3);
        wait_valid("hold_valid", 30);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {31'd0, out_valid}, 32'd0);
        check("async_rst_data", 32'(out_data), 32'd0);
        check("async_rst_cnt", 32'(out_cnt), 32'd0);
        check("async_rst_ren", {31'd0, fifo_ren}, 32'd0);
        sb.delete();
        tick(2);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_ren", {31'd0, fifo_ren}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
